bcd_counter_display: RTL

Parametrised multi-digit decimal counter with integrated tick prescaler and per-digit seven-segment drive. It replaces the single-digit, ripple-clocked counter generation with a fully synchronous single-clock design. It adds up/down counting, enable, synchronous clear, wrap signalling and leading-zero blanking. It sits between the board clock and the seven-segment display pins of the lab top level.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_decode.sv | 32 +++
 rtl/bcd_counter_display.sv | 118 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and the BCD digit type used by the counter
// and its per-digit decoders.
package seg7_pkg;

  typedef logic [3:0] bcd_digit_t;

  // Active-low, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD-to-seven-segment decoder for one digit. A raised blank
// flag, or any non-BCD nibble, turns every segment off.
module seg7_decode
  import seg7_pkg::*;
(
  input  bcd_digit_t  digit_i,
  input  logic        blank_i,
  output logic [6:0]  seg_o
);

  always_comb begin
    // NOTE: the output gets a default before the case, so no path through
    // this block leaves it unassigned and no latch can be inferred.
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_counter_display.sv
// Multi-digit up/down BCD counter with a tick prescaler, wrap pulse, LED
// toggle and registered seven-segment outputs with leading-zero blanking.
module bcd_counter_display
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50_000_000,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  led,
  output logic                  wrap
);

  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]              presc_q, presc_d;
  bcd_digit_t [DIGITS-1:0]    digit_q, digit_d;
  logic                       led_q, led_d;
  logic                       wrap_q, wrap_d;
  logic [7*DIGITS-1:0]        seg_q, seg_d, seg_rst;
  logic [DIGITS-1:0]          blank;
  logic                       tick;
  logic                       carry;
  logic                       zero_run;

  assign tick = en && (presc_q == PRESC_MAX);

  // Ripple the carry/borrow from digit 0 upward; a carry surviving the top
  // digit means the whole count rolled over.
  always_comb begin
    presc_d = presc_q;
    digit_d = digit_q;
    led_d   = led_q;
    wrap_d  = 1'b0;
    carry   = 1'b1;
    if (clr) begin
      presc_d = '0;
      digit_d = '0;
      led_d   = 1'b0;
    end else if (en) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        led_d = ~led_q;
        for (int i = 0; i < DIGITS; i++) begin
          if (carry) begin
            if (up) begin
              if (digit_q[i] >= 4'd9) begin
                digit_d[i] = 4'd0;
              end else begin
                digit_d[i] = digit_q[i] + 4'd1;
                carry      = 1'b0;
              end
            end else begin
              if (digit_q[i] == 4'd0) begin
                digit_d[i] = 4'd9;
              end else begin
                digit_d[i] = digit_q[i] - 4'd1;
                carry      = 1'b0;
              end
            end
          end
        end
        wrap_d = carry;
      end
    end
  end

  // A digit above 0 blanks while it and every digit above it are zero.
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run && (digit_q[i] == 4'd0);
      blank[i] = (BLANK_LZ != 0) && zero_run;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    seg7_decode u_dec (
      .digit_i (digit_q[g]),
      .blank_i (blank[g]),
      .seg_o   (seg_d[7*g +: 7])
    );
    assign seg_rst[7*g +: 7] = ((g > 0) && (BLANK_LZ != 0)) ? SEG_BLANK : SEG_0;
  end

  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // the pre-edge values, whatever order the statements appear in.
    if (rst) begin
      presc_q <= '0;
      digit_q <= '0;
      led_q   <= 1'b0;
      wrap_q  <= 1'b0;
      seg_q   <= seg_rst;
    end else begin
      presc_q <= presc_d;
      digit_q <= digit_d;
      led_q   <= led_d;
      wrap_q  <= wrap_d;
      seg_q   <= seg_d;
    end
  end

  assign bcd  = digit_q;
  assign seg  = seg_q;
  assign led  = led_q;
  assign wrap = wrap_q;

endmodule
